// File: rtl/txt_pkg.sv
// Shared definitions for the 70x30 character terminal.
// Purpose : screen geometry, video RAM address width, the ASCII control
//           codes the writer reacts to, and the writer's state encoding.
// Ports   : none (package).
package txt_pkg;

    localparam int unsigned COLS   = 70;
    localparam int unsigned ROWS   = 30;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned CELLS  = COLS * ROWS;

    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_FF    = 8'h0C;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_TILDE = 8'h7E;

    typedef enum logic [1:0] {
        CLR_ALL = 2'd0,
        IDLE    = 2'd1,
        CLR_ROW = 2'd2
    } txt_state_t;

endpackage

// File: rtl/text_addr_map.sv
// Screen position to video RAM address translation, shared by the writer and
// the VGA read side.
// Purpose : rotate the screen row by top_row (ring-buffer scrolling) and
//           linearise (physical row, column) into a RAM address.
// Ports   : top_row  in  5       physical row shown at screen row 0
//           row      in  5       screen-relative row 0..ROWS-1
//           col      in  7       column 0..COLS-1
//           phys     out 5       physical RAM row
//           addr     out ADDR_W  phys*COLS + col
module text_addr_map
    import txt_pkg::*;
(
    input  logic [4:0]        top_row,
    input  logic [4:0]        row,
    input  logic [6:0]        col,
    output logic [4:0]        phys,
    output logic [ADDR_W-1:0] addr
);

    logic [5:0] sum;

    always_comb begin
        sum = {1'b0, top_row} + {1'b0, row};
        // Both operands are below ROWS, so one conditional subtract wraps.
        if (sum >= 6'(ROWS)) begin
            phys = 5'(sum - 6'(ROWS));
        end else begin
            phys = sum[4:0];
        end
        addr = ADDR_W'(phys) * ADDR_W'(COLS) + ADDR_W'(col);
    end

endmodule

// File: rtl/text_term_writer.sv
// Write side of the 70x30 character terminal.
// Purpose : accepts ASCII codes over valid/ready, keeps the cursor, per-row
//           line lengths and ring-buffer scroll offset, and drives the video
//           RAM write port (registered address/data/enable).
// Ports   : clk        in   1       system clock, posedge
//           clrn       in   1       asynchronous active-low reset
//           key_valid  in   1       key_ascii valid, held until accepted
//           key_ascii  in   8       ASCII code
//           key_ready  out  1       code can be accepted this cycle
//           ram_addr   out  ADDR_W  video RAM write address
//           ram_data   out  8       video RAM write data
//           ram_wren   out  1       video RAM write enable
//           cur_row    out  5       cursor row (screen-relative)
//           cur_col    out  7       cursor column
//           top_row    out  5       physical row shown at screen row 0
//           busy       out  1       full-screen or row clear in progress
module text_term_writer
    import txt_pkg::*;
(
    input  logic              clk,
    input  logic              clrn,
    input  logic              key_valid,
    input  logic [7:0]        key_ascii,
    output logic              key_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_data,
    output logic              ram_wren,
    output logic [4:0]        cur_row,
    output logic [6:0]        cur_col,
    output logic [4:0]        top_row,
    output logic              busy
);

    txt_state_t        state, state_n;
    logic [ADDR_W-1:0] cnt, cnt_n;
    logic [4:0]        row_n, top_n;
    logic [6:0]        col_n;
    logic [ADDR_W-1:0] addr_n;
    logic [7:0]        data_n;
    logic              wren_n;

    // Line length per physical row; indexing by physical row makes the
    // table scroll together with top_row for free.
    logic [6:0]        len [ROWS];
    logic              len_we, len_clr;
    logic [6:0]        len_wd;

    logic [4:0]        map_row, map_phys;
    logic [6:0]        map_col;
    logic [ADDR_W-1:0] map_addr;

    logic              xfer, is_print, do_nl;

    assign key_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign xfer      = key_valid & key_ready;
    assign is_print  = (key_ascii >= ASCII_SPACE) && (key_ascii <= ASCII_TILDE);

    // One mapper serves every write: the cursor cell, the cell left of it
    // (backspace), the end of the previous row, or the row-clear column.
    always_comb begin
        map_row = cur_row;
        map_col = cur_col;
        if (state == CLR_ROW) begin
            map_col = cnt[6:0];
        end else if (state == IDLE && key_ascii == ASCII_BS) begin
            if (cur_col != 7'd0) begin
                map_col = cur_col - 7'd1;
            end else begin
                map_row = (cur_row != 5'd0) ? cur_row - 5'd1 : cur_row;
                map_col = 7'(COLS - 1);
            end
        end
    end

    text_addr_map u_map (
        .top_row (top_row),
        .row     (map_row),
        .col     (map_col),
        .phys    (map_phys),
        .addr    (map_addr)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        row_n   = cur_row;
        col_n   = cur_col;
        top_n   = top_row;
        addr_n  = ram_addr;
        data_n  = ram_data;
        wren_n  = 1'b0;
        len_we  = 1'b0;
        len_wd  = '0;
        len_clr = 1'b0;
        do_nl   = 1'b0;

        case (state)
            CLR_ALL: begin
                wren_n = 1'b1;
                addr_n = cnt;
                data_n = ASCII_SPACE;
                cnt_n  = cnt + ADDR_W'(1);
                if (cnt == ADDR_W'(CELLS - 1)) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            end

            CLR_ROW: begin
                wren_n = 1'b1;
                addr_n = map_addr;
                data_n = ASCII_SPACE;
                cnt_n  = cnt + ADDR_W'(1);
                if (cnt == ADDR_W'(COLS - 1)) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            end

            IDLE: begin
                if (xfer) begin
                    if (is_print) begin
                        wren_n = 1'b1;
                        addr_n = map_addr;
                        data_n = key_ascii;
                        if (cur_col == 7'(COLS - 1)) begin
                            len_we = 1'b1;
                            len_wd = 7'(COLS);
                            do_nl  = 1'b1;
                        end else begin
                            col_n = cur_col + 7'd1;
                        end
                    end else if (key_ascii == ASCII_CR) begin
                        len_we = 1'b1;
                        len_wd = cur_col;
                        do_nl  = 1'b1;
                    end else if (key_ascii == ASCII_BS) begin
                        if (cur_col != 7'd0) begin
                            col_n  = cur_col - 7'd1;
                            wren_n = 1'b1;
                            addr_n = map_addr;
                            data_n = ASCII_SPACE;
                        end else if (cur_row != 5'd0) begin
                            // A full previous row has no free cell after its
                            // text, so the cursor lands on its last cell and
                            // erases it; otherwise it sits just past the text.
                            row_n = cur_row - 5'd1;
                            if (len[map_phys] == 7'(COLS)) begin
                                col_n  = 7'(COLS - 1);
                                wren_n = 1'b1;
                                addr_n = map_addr;
                                data_n = ASCII_SPACE;
                            end else begin
                                col_n = len[map_phys];
                            end
                        end
                    end else if (key_ascii == ASCII_FF) begin
                        row_n   = '0;
                        col_n   = '0;
                        top_n   = '0;
                        len_clr = 1'b1;
                        cnt_n   = '0;
                        state_n = CLR_ALL;
                    end
                end
            end

            default: begin
                state_n = CLR_ALL;
                cnt_n   = '0;
            end
        endcase

        if (do_nl) begin
            col_n = '0;
            if (cur_row == 5'(ROWS - 1)) begin
                top_n = (top_row == 5'(ROWS - 1)) ? 5'd0 : top_row + 5'd1;
            end else begin
                row_n = cur_row + 5'd1;
            end
            cnt_n   = '0;
            state_n = CLR_ROW;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state    <= CLR_ALL;
            cnt      <= '0;
            cur_row  <= '0;
            cur_col  <= '0;
            top_row  <= '0;
            ram_addr <= '0;
            ram_data <= ASCII_SPACE;
            ram_wren <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            cur_row  <= row_n;
            cur_col  <= col_n;
            top_row  <= top_n;
            ram_addr <= addr_n;
            ram_data <= data_n;
            ram_wren <= wren_n;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int unsigned i = 0; i < ROWS; i++) begin
                len[i] <= '0;
            end
        end else if (len_clr) begin
            for (int unsigned i = 0; i < ROWS; i++) begin
                len[i] <= '0;
            end
        end else if (len_we) begin
            len[map_phys] <= len_wd;
        end
    end

endmodule

// File: tb/tb_text_term_writer.sv
module tb_text_term_writer;

    localparam int T_COLS = 70;
    localparam int T_ROWS = 30;

    logic        clk = 1'b0;
    logic        clrn;
    logic        key_valid;
    logic [7:0]  key_ascii;
    logic        key_ready;
    logic [11:0] ram_addr;
    logic [7:0]  ram_data;
    logic        ram_wren;
    logic [4:0]  cur_row;
    logic [6:0]  cur_col;
    logic [4:0]  top_row;
    logic        busy;

    text_term_writer dut (
        .clk       (clk),
        .clrn      (clrn),
        .key_valid (key_valid),
        .key_ascii (key_ascii),
        .key_ready (key_ready),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .ram_wren  (ram_wren),
        .cur_row   (cur_row),
        .cur_col   (cur_col),
        .top_row   (top_row),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  m_row, m_col, m_top;
    int  m_len[T_ROWS];

    function automatic int m_addr(input int r, input int c);
        return ((m_top + r) % T_ROWS) * T_COLS + c;
    endfunction

    function automatic void push(input int a, input int d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endfunction

    function automatic void model_clear_all();
        m_row = 0; m_col = 0; m_top = 0;
        for (int i = 0; i < T_ROWS; i++) m_len[i] = 0;
        for (int a = 0; a < T_COLS * T_ROWS; a++) push(a, 32);
    endfunction

    function automatic void model_newline();
        m_col = 0;
        if (m_row < T_ROWS - 1) m_row++;
        else m_top = (m_top + 1) % T_ROWS;
        for (int c = 0; c < T_COLS; c++) push(m_addr(m_row, c), 32);
    endfunction

    function automatic void model_accept(input int code);
        if (code >= 32 && code <= 126) begin
            push(m_addr(m_row, m_col), code);
            if (m_col == T_COLS - 1) begin
                m_len[(m_top + m_row) % T_ROWS] = T_COLS;
                model_newline();
            end else begin
                m_col++;
            end
        end else if (code == 13) begin
            m_len[(m_top + m_row) % T_ROWS] = m_col;
            model_newline();
        end else if (code == 8) begin
            if (m_col > 0) begin
                m_col--;
                push(m_addr(m_row, m_col), 32);
            end else if (m_row > 0) begin
                m_row--;
                if (m_len[(m_top + m_row) % T_ROWS] == T_COLS) begin
                    m_col = T_COLS - 1;
                    push(m_addr(m_row, m_col), 32);
                end else begin
                    m_col = m_len[(m_top + m_row) % T_ROWS];
                end
            end
        end else if (code == 12) begin
            model_clear_all();
        end
    endfunction

    // ---------------- write monitor ----------------
    int wr_cnt    = 0;
    int last_addr = -1;
    int last_data = -1;

    always @(negedge clk) begin
        if (clrn && ram_wren) begin
            wr_t e;
            wr_cnt++;
            last_addr = int'(ram_addr);
            last_data = int'(ram_data);
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", int'(ram_addr), -1);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", int'(ram_addr), e.addr);
                chk("wr_data", int'(ram_data), e.data);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] c);
        int w;
        w = 0;
        @(negedge clk);
        key_ascii = c;
        key_valid = 1'b1;
        while (!key_ready && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (!key_ready) begin
            chk("send_timeout", 0, 1);
            key_valid = 1'b0;
            return;
        end
        model_accept(int'(c));
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        chk("cur_row", int'(cur_row), m_row);
        chk("cur_col", int'(cur_col), m_col);
        chk("top_row", int'(top_row), m_top);
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        do begin
            @(negedge clk);
            #1;
            w++;
        end while (!key_ready && w < 3000);
        if (!key_ready) chk("idle_timeout", 0, 1);
    endtask

    typedef struct {
        logic [7:0] code;
        int         row;
        int         col;
        int         nwr;
    } vec_t;

    vec_t vt[13];

    initial begin
        int cyc;
        int r;
        int ff_left;
        logic [7:0] rc;

        // Starting from cursor (0,2), top_row 0, all line lengths 0.
        vt[0]  = '{8'h08, 0, 1, 1};
        vt[1]  = '{8'h0D, 1, 0, 70};
        vt[2]  = '{8'h08, 0, 1, 0};
        vt[3]  = '{8'h07, 0, 1, 0};
        vt[4]  = '{8'h7E, 0, 2, 1};
        vt[5]  = '{8'h08, 0, 1, 1};
        vt[6]  = '{8'h08, 0, 0, 1};
        vt[7]  = '{8'h08, 0, 0, 0};
        vt[8]  = '{8'h7F, 0, 0, 0};
        vt[9]  = '{8'h20, 0, 1, 1};
        vt[10] = '{8'h0D, 1, 0, 70};
        vt[11] = '{8'h0D, 2, 0, 70};
        vt[12] = '{8'h08, 1, 0, 0};

        clrn      = 1'b0;
        key_valid = 1'b0;
        key_ascii = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_wren",  int'(ram_wren), 0);
        chk("rst_addr",  int'(ram_addr), 0);
        chk("rst_data",  int'(ram_data), 32);
        chk("rst_row",   int'(cur_row), 0);
        chk("rst_col",   int'(cur_col), 0);
        chk("rst_top",   int'(top_row), 0);
        chk("rst_ready", int'(key_ready), 0);
        chk("rst_busy",  int'(busy), 1);

        // Power-up clear: 2100 writes, then ready.
        @(negedge clk);
        #2;
        exp_q.delete();
        model_clear_all();
        wr_cnt = 0;
        clrn   = 1'b1;
        cyc    = 0;
        while (cyc < 3000 && !key_ready) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("clr_all_edges", cyc, 2100);
        chk("clr_all_busy", int'(busy), 0);
        @(negedge clk);
        #1;
        chk("clr_all_writes", wr_cnt, 2100);
        chk("clr_all_last", last_addr, 2099);
        chk("clr_all_q", exp_q.size(), 0);

        // Back-to-back printable codes.
        send(8'h41);
        chk("b2b_ready", int'(key_ready), 1);
        send(8'h42);
        @(negedge clk);
        #1;
        chk("b2b_addr", last_addr, 1);
        chk("b2b_data", last_data, 8'h42);
        chk("b2b_col", int'(cur_col), 2);

        foreach (vt[i]) begin
            wr_cnt = 0;
            send(vt[i].code);
            wait_idle();
            chk($sformatf("vec%0d_row", i), int'(cur_row), vt[i].row);
            chk($sformatf("vec%0d_col", i), int'(cur_col), vt[i].col);
            chk($sformatf("vec%0d_top", i), int'(top_row), 0);
            chk($sformatf("vec%0d_nwr", i), wr_cnt, vt[i].nwr);
        end

        // Form feed with the next code held by the producer meanwhile.
        send(8'h0C);
        repeat (500) @(negedge clk);
        #1;
        chk("ff_busy", int'(busy), 1);
        chk("ff_ready", int'(key_ready), 0);
        chk("ff_row", int'(cur_row), 0);
        chk("ff_col", int'(cur_col), 0);
        send(8'h58);
        chk("ff_held_col", int'(cur_col), 1);
        send(8'h0D);
        wait_idle();
        wr_cnt = 0;
        send(8'h08);
        wait_idle();
        chk("bs_up_nwr", wr_cnt, 0);
        chk("bs_up_row", int'(cur_row), 0);
        chk("bs_up_col", int'(cur_col), 1);

        // Full row wrap, then backspace onto the last cell of the full row.
        send(8'h08);
        for (int i = 0; i < 70; i++) send(8'h61);
        chk("wrap_row", int'(cur_row), 1);
        chk("wrap_col", int'(cur_col), 0);
        wait_idle();
        send(8'h08);
        @(negedge clk);
        #1;
        chk("wrap_bs_addr", last_addr, 69);
        chk("wrap_bs_data", last_data, 32);
        chk("wrap_bs_col", int'(cur_col), 69);

        // Scroll at the bottom row.
        for (int i = 0; i < 29; i++) send(8'h0D);
        chk("bottom_row", int'(cur_row), 29);
        chk("bottom_top", int'(top_row), 0);
        send(8'h59);
        send(8'h0D);
        chk("scroll_top", int'(top_row), 1);
        chk("scroll_row", int'(cur_row), 29);
        wait_idle();
        chk("scroll_clear_last", last_addr, 69);
        send(8'h5A);
        @(negedge clk);
        #1;
        chk("scroll_wr_addr", last_addr, 0);
        chk("scroll_wr_data", last_data, 8'h5A);

        // Reset pulse in the middle of a full clear.
        send(8'h0C);
        repeat (300) @(negedge clk);
        #2;
        clrn = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_wren", int'(ram_wren), 0);
        chk("mid_rst_addr", int'(ram_addr), 0);
        chk("mid_rst_busy", int'(busy), 1);
        @(negedge clk);
        #2;
        model_clear_all();
        wr_cnt = 0;
        clrn   = 1'b1;
        wait_idle();
        chk("mid_rst_writes", wr_cnt, 2100);
        chk("mid_rst_last", last_addr, 2099);

        // Randomised traffic against the model.
        ff_left = 2;
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 60)                       rc = 8'($urandom_range(32, 126));
            else if (r < 75)                  rc = 8'h0D;
            else if (r < 92)                  rc = 8'h08;
            else if (r < 93 && ff_left > 0) begin
                rc = 8'h0C;
                ff_left--;
            end else                          rc = 8'($urandom_range(0, 255));
            send(rc);
        end
        wait_idle();
        chk("final_q_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
